// File: rtl/multivar_pkg.sv
// Shared types for the timed multi-variable writer: target select, FSM state
// and the buffered command record.
package multivar_pkg;

    localparam int MV_DW    = 32;
    localparam int MV_DLY_W = 8;

    typedef enum logic [1:0] {
        SEL_A    = 2'd0,
        SEL_B    = 2'd1,
        SEL_C    = 2'd2,
        SEL_RSVD = 2'd3
    } var_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wr_state_e;

    typedef struct packed {
        logic [MV_DLY_W-1:0] delay;
        var_sel_e            sel;
        logic [MV_DW-1:0]    value;
    } wr_cmd_t;

endpackage

// File: rtl/multivar_cmd_fifo.sv
// Synchronous command FIFO of wr_cmd_t. Pointers carry one extra wrap bit so
// that full and empty can be told apart without a separate counter.
module multivar_cmd_fifo
    import multivar_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wr_cmd_t din,
    input  logic    pop,
    output wr_cmd_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    wr_cmd_t     r_mem [DEPTH];

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign head  = r_mem[r_rd_ptr[AW-1:0]];

    // Storage and pointer update; push is ignored when full, pop when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {(AW+1){1'b0}};
            r_rd_ptr <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                r_mem[r_wr_ptr[AW-1:0]] <= din;
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (pop && !empty) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end

endmodule

// File: rtl/multivar_sched_writer.sv
// Timed writer: buffers (delay, target, value) commands and applies each to
// var_a/b/c after its programmed idle cycles, relative to the previous write.
module multivar_sched_writer
    import multivar_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = MV_DW,
    parameter int DLY_W = MV_DLY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DLY_W-1:0] cmd_delay,
    input  logic [1:0]       cmd_sel,
    input  logic [DW-1:0]    cmd_value,
    output logic [DW-1:0]    var_a,
    output logic [DW-1:0]    var_b,
    output logic [DW-1:0]    var_c,
    output logic             wr_strobe,
    output logic [1:0]       wr_sel,
    output logic             err_sel,
    output logic             busy
);

    wr_state_e        r_state;
    wr_state_e        w_state_nxt;
    logic [DLY_W-1:0] r_cnt;
    var_sel_e         r_sel;
    logic [DW-1:0]    r_value;
    logic [DW-1:0]    r_var_a;
    logic [DW-1:0]    r_var_b;
    logic [DW-1:0]    r_var_c;
    logic             r_wr_strobe;
    var_sel_e         r_wr_sel;
    logic             r_err_sel;

    logic    w_full;
    logic    w_empty;
    logic    w_push;
    logic    w_pop;
    logic    w_load;
    logic    w_dec;
    logic    w_retire;
    wr_cmd_t w_din;
    wr_cmd_t w_head;

    assign w_push    = cmd_valid && !w_full;
    assign w_din     = '{delay: cmd_delay, sel: var_sel_e'(cmd_sel), value: cmd_value};
    assign cmd_ready = !w_full;
    assign busy      = !w_empty || (r_state != ST_IDLE);

    multivar_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (w_din),
        .pop   (w_pop),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Next-state and control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt != {DLY_W{1'b0}}) begin
                    w_dec = 1'b1;
                end else begin
                    // Retire and, if possible, chain straight into the next entry.
                    w_retire = 1'b1;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, working entry and delay counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= {DLY_W{1'b0}};
            r_sel   <= SEL_A;
            r_value <= {DW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_cnt   <= w_head.delay;
                r_sel   <= w_head.sel;
                r_value <= w_head.value;
            end else if (w_dec) begin
                r_cnt <= r_cnt - {{(DLY_W-1){1'b0}}, 1'b1};
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Variable registers and one-cycle write/error indications.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_var_a     <= {DW{1'b0}};
            r_var_b     <= {DW{1'b0}};
            r_var_c     <= {DW{1'b0}};
            r_wr_strobe <= 1'b0;
            r_wr_sel    <= SEL_A;
            r_err_sel   <= 1'b0;
        end else begin
            r_wr_strobe <= w_retire && (r_sel != SEL_RSVD);
            r_err_sel   <= w_retire && (r_sel == SEL_RSVD);
            if (w_retire && (r_sel != SEL_RSVD)) begin
                r_wr_sel <= r_sel;
            end else begin
                r_wr_sel <= r_wr_sel;
            end
            if (w_retire) begin
                case (r_sel)
                    SEL_A:   r_var_a <= r_value;
                    SEL_B:   r_var_b <= r_value;
                    SEL_C:   r_var_c <= r_value;
                    default: r_var_a <= r_var_a;
                endcase
            end else begin
                r_var_a <= r_var_a;
            end
        end
    end

    assign var_a     = r_var_a;
    assign var_b     = r_var_b;
    assign var_c     = r_var_c;
    assign wr_strobe = r_wr_strobe;
    assign wr_sel    = r_wr_sel;
    assign err_sel   = r_err_sel;

endmodule

// File: doc/multivar_sched_writer.md
# multivar_sched_writer

Timed multi-variable writer for the scheduler test harness: accepts a stream of (delay, target, value) commands, buffers them, and applies each as a register write to one of three shared 32-bit signed variables (a, b, c) after the programmed number of idle cycles. It is the synthesizable producer side of the multi-variable wait tests. Downstream condition watchers observe `var_a/b/c` and `wr_strobe`.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `DW`, 32: variable and value width, two's-complement signed.
- `DLY_W`, 8: delay field width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept; equals `!full`.
- `cmd_delay`  in  DLY_W  idle cycles before this write, relative to the previous write.
- `cmd_sel`  in  2  target: 0=a, 1=b, 2=c, 3=reserved.
- `cmd_value`  in  DW  value to write.
- `var_a`, `var_b`, `var_c`  out  DW each  current variable values (registered).
- `wr_strobe`  out  1  one-cycle pulse, high in the cycle a new value first appears.
- `wr_sel`  out  2  target of the current `wr_strobe`; holds last value otherwise.
- `err_sel`  out  1  one-cycle pulse when a reserved-target command retires.
- `busy`  out  1  FIFO non-empty or state ≠ IDLE.

## Operation
- Command accepted on any edge with `cmd_valid && cmd_ready`; FIFO stores {delay, sel, value}.
- FSM states: IDLE, WAIT.
  - IDLE, FIFO empty: stay.
  - IDLE, FIFO non-empty: pop head into working regs, `cnt <= delay`, go WAIT.
  - WAIT, `cnt != 0`: `cnt <= cnt - 1`.
  - WAIT, `cnt == 0`: retire the entry. For sel 0..2, write `value` into the selected variable, set `wr_strobe`, and set `wr_sel`. For sel 3, set `err_sel` and leave the variables unchanged. Then, if the FIFO is non-empty, pop the next head in the same edge and stay in WAIT. Otherwise go to IDLE.
- Non-selected variables always hold their values.
- Push and pop may occur on the same edge, including when the FIFO is non-full. When full, `cmd_ready` is 0, so there is no push.
- FIFO pointers are `$clog2(DEPTH)+1` bits and wrap naturally. Full/empty are decided by comparing the MSB and the remaining pointer bits.
- Delay is unsigned. Max delay `2^DLY_W-1` is legal, and `cnt` never underflows.

## Timing
- Reset values: `var_a/b/c` = 0, `wr_strobe` = 0, `wr_sel` = 0, `err_sel` = 0, `busy` = 0, `cmd_ready` = 1, FIFO empty, state IDLE, `cnt` = 0.
- `rst` mid-operation discards all FIFO contents and the in-flight entry, and zeroes all variables on that edge.
- Command pushed into an empty idle block at edge E0: loaded at E1, written at E(2+delay). `wr_strobe` is high in cycle E(2+delay)…E(3+delay).
- Back-to-back buffered entries: write k+1 lands `delay(k+1)+1` cycles after write k. Delay 0 therefore gives writes on consecutive cycles.
- `busy` is combinational from the FIFO count and state. It is high from the edge after the first push until the edge of the last retire.

## Structure
- Package `multivar_pkg` holds:
  - `typedef enum logic [1:0] {SEL_A, SEL_B, SEL_C, SEL_RSVD} var_sel_e`
  - `typedef enum logic {ST_IDLE, ST_WAIT} wr_state_e`
  - the packed command struct `wr_cmd_t` (delay, sel, value)
- Sub-module `multivar_cmd_fifo` is a parameterized synchronous FIFO of `wr_cmd_t`, exposing `full`, `empty`, `push`, `pop`, and `head`. The top module holds the FSM, counter, and variable registers.

## Test plan
- Reset then idle: no commands for 10 cycles → all outputs at reset values, `busy` = 0, `cmd_ready` = 1.
- Sequence (1,b,1), (0,a,2), (0,c,3), (0,c,4), (0,b,5), all pushed back-to-back from edge 0:
  - required writes: b=1, then a=2 one cycle later, then c=3, c=4, b=5 on consecutive cycles;
  - final state: a=2, b=5, c=4;
  - exactly five `wr_strobe` pulses with `wr_sel` 1, 0, 2, 2, 1.
- Full FIFO: with DEPTH=4, push 6 commands each with delay 10 and `cmd_valid` held → `cmd_ready` drops after the 5th accept (4 buffered + 1 in WAIT). It rises on the edge the 2nd entry is loaded, and all 6 commands retire in order.
- Reserved target: (0,3,0x55) followed by (0,a,7) → one `err_sel` pulse and no variable change, then a=7 one cycle later.
- Max delay: (255,c,−1) → `var_c` = 0xFFFFFFFF exactly 257 cycles after the push edge, and no early strobe.
- Reset mid-WAIT: push (20,a,9), assert `rst` at cycle 5 → a stays 0, `busy` = 0, and no strobe for the next 30 cycles.
